// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd
//   Start/stop/clear stopwatch counting MM:SS in BCD from a slow divided
//   clock (tick_in) that is sampled as a plain level on the system clock.
//   Every TICKS_PER_SEC rising edges of tick_in advance the time by one
//   second while running.
//
// Parameters
//   TICKS_PER_SEC  tick_in rises per counted second (>= 1)
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   rst         asynchronous reset, active low
//   tick_in     divided clock level from the counter stage (asynchronous)
//   start_stop  one-cycle pulse, toggles run/pause (IDLE starts running)
//   clear       one-cycle pulse, back to 00:00 and IDLE
//   sec_ones    BCD seconds units   (0-9)
//   sec_tens    BCD seconds tens    (0-5)
//   min_ones    BCD minutes units   (0-9)
//   min_tens    BCD minutes tens    (0-5)
//   running     high while in RUN
//   rollover    one-cycle pulse on 59:59 -> 00:00
//
// Optional feature (macro STOPWATCH_LAP_HOLD_EN)
//   lap         one-cycle pulse, toggles display hold in RUN or PAUSE
//   lap_held    high while the displayed digits are frozen
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | stopped at 00:00, ticks ignored
// RUN   | counting ticks
// PAUSE | stopped, digits and partial second held

module stopwatch_bcd #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
  output logic       lap_held,
`endif
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic            s1, s2, s3;
  logic            tick_rise;
  logic [PW-1:0]   presc_q, presc_n;
  logic [3:0]      so_q, so_n;
  logic [2:0]      st_q, st_n;
  logic [3:0]      mo_q, mo_n;
  logic [2:0]      mt_q, mt_n;
  logic            roll_n;

  // Two flops resynchronise tick_in; s3 remembers the previous level so one
  // rise of tick_in yields exactly one single-cycle tick_rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      so_q     <= '0;
      st_q     <= '0;
      mo_q     <= '0;
      mt_q     <= '0;
      running  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      state_q  <= state_n;
      presc_q  <= presc_n;
      so_q     <= so_n;
      st_q     <= st_n;
      mo_q     <= mo_n;
      mt_q     <= mt_n;
      running  <= (state_n == RUN);
      rollover <= roll_n;
    end
  end

  // Clear wins over everything. In RUN a tick is counted using the current
  // state, so a tick arriving with start_stop still lands before the pause.
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    so_n    = so_q;
    st_n    = st_q;
    mo_n    = mo_q;
    mt_n    = mt_q;
    roll_n  = 1'b0;
    if (clear) begin
      state_n = IDLE;
      presc_n = '0;
      so_n    = '0;
      st_n    = '0;
      mo_n    = '0;
      mt_n    = '0;
    end else begin
      if (state_q == RUN && tick_rise) begin
        if (presc_q == PRESC_MAX) begin
          presc_n = '0;
          if (so_q == 4'd9) begin
            so_n = 4'd0;
            if (st_q == 3'd5) begin
              st_n = 3'd0;
              if (mo_q == 4'd9) begin
                mo_n = 4'd0;
                if (mt_q == 3'd5) begin
                  mt_n   = 3'd0;
                  roll_n = 1'b1;
                end else begin
                  mt_n = mt_q + 3'd1;
                end
              end else begin
                mo_n = mo_q + 4'd1;
              end
            end else begin
              st_n = st_q + 3'd1;
            end
          end else begin
            so_n = so_q + 4'd1;
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      if (start_stop) begin
        case (state_q)
          IDLE:    state_n = RUN;
          RUN:     state_n = PAUSE;
          PAUSE:   state_n = RUN;
          default: state_n = IDLE;
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic held_q, held_n;

  always_comb begin
    held_n = held_q;
    if (clear) begin
      held_n = 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      held_n = ~held_q;
    end
  end

  // The display registers follow the next live count unless hold is in
  // effect after this edge; on entering hold they simply keep the value they
  // already show, which is the live count at the moment lap arrived.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q   <= 1'b0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else begin
      held_q <= held_n;
      if (!held_n) begin
        sec_ones <= so_n;
        sec_tens <= st_n;
        min_ones <= mo_n;
        min_tens <= mt_n;
      end
    end
  end

  assign lap_held = held_q;
`else
  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
`endif

endmodule
